// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run/step/halt controller for the RV32I core on the DE2 board. The core runs
//   on the board clock and is advanced only by single-cycle pulses on cpu_ce.
//   Three ways to advance it: fast run (a pulse on every clk), slow run (one
//   pulse per slow tick), and single-step from a debounced push-key.
//
//   Optional feature: define BREAKPOINT_EN to build the PC breakpoint
//   comparator and the BRK state. Without it, pc_in and bp_addr are ignored
//   and bp_hit is tied low.
//
// Ports
//   clk         board clock (CLOCK_50)
//   rst         synchronous reset, active-high
//   run_sw      async switch, 1 = run, 0 = halt
//   fast_sw     async switch, 1 = pulse every clk, 0 = slow tick rate
//   step_btn_n  async raw key, active-low; one press gives one step
//   pc_in       current core PC (breakpoint compare only)
//   bp_addr     breakpoint address (breakpoint compare only)
//   cpu_ce      core clock-enable, one-clk pulses
//   halted      high in HALT or BRK
//   bp_hit      high in BRK
//   heartbeat   toggles on every slow tick, in any state
//   cycle_cnt   number of cpu_ce pulses issued, saturating at all-ones
//
// state | meaning
// ------+------------------------------------------------------------
// HALT  | core stopped; a debounced key press issues one cpu_ce
// RUN   | core free-running at the fast or slow rate
// BRK   | stopped on a breakpoint; steps allowed, run_sw must toggle
module cpu_run_ctrl #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SLOW_HZ      = 10,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             fast_sw,
  input  logic             step_btn_n,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      bp_addr,
  output logic             cpu_ce,
  output logic             halted,
  output logic             bp_hit,
  output logic             heartbeat,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned DIV   = CLK_HZ / SLOW_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_BRK  = 2'd2
  } state_t;

  logic [1:0]       run_sync;
  logic [1:0]       fast_sync;
  logic [1:0]       step_sync;
  logic             run_s;
  logic             fast_s;
  logic             step_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [DB_W-1:0]  db_cnt;
  logic             step_db;
  logic             step_req;
  state_t           state_q;
  state_t           state_d;
  logic             ce_d;
  logic             run_ce;

  // Two-flop synchronizers; the key idles high so its chain resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_sync  <= 2'b00;
      fast_sync <= 2'b00;
      step_sync <= 2'b11;
    end else begin
      run_sync  <= {run_sync[0], run_sw};
      fast_sync <= {fast_sync[0], fast_sw};
      step_sync <= {step_sync[0], step_btn_n};
    end
  end

  assign run_s  = run_sync[1];
  assign fast_s = fast_sync[1];
  assign step_s = step_sync[1];

  // Free-running slow-tick divider. div_cnt holds the clks remaining before
  // the next tick, so reload value DIV-1 is the same phase as a count of 0.
  assign tick = (div_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= DIV_LAST;
      heartbeat <= 1'b0;
    end else begin
      if (tick) begin
        div_cnt   <= DIV_LAST;
        heartbeat <= ~heartbeat;
      end else begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
    end
  end

  // Debouncer: db_cnt counts down while the synced key disagrees with the
  // debounced level and reloads whenever they agree, so the level only flips
  // after DEBOUNCE_CYC consecutive disagreeing clks. Only the press (1->0)
  // raises step_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_db  <= 1'b1;
      db_cnt   <= DB_LAST;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (step_s == step_db) begin
        db_cnt <= DB_LAST;
      end else if (db_cnt == '0) begin
        step_db  <= step_s;
        db_cnt   <= DB_LAST;
        step_req <= ~step_s;
      end else begin
        db_cnt <= db_cnt - DB_W'(1);
      end
    end
  end

`ifdef BREAKPOINT_EN
  logic bp_match;
  assign bp_match = (pc_in == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{pc_in, bp_addr};
`endif

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    run_ce  = fast_s | tick;
    case (state_q)
      ST_HALT: begin
        ce_d = step_req;
        if (run_s) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run_s) begin
          state_d = ST_HALT;
        end else begin
          ce_d = run_ce;
`ifdef BREAKPOINT_EN
          // The pulse that would execute the breakpoint PC is swallowed.
          if (run_ce && bp_match) begin
            ce_d    = 1'b0;
            state_d = ST_BRK;
          end
`endif
        end
      end
      ST_BRK: begin
        // Stepping ignores the comparator so the core can leave the bp PC.
        ce_d = step_req;
        if (!run_s) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HALT;
      cpu_ce  <= 1'b0;
    end else begin
      state_q <= state_d;
      cpu_ce  <= ce_d;
    end
  end

  assign halted = (state_q != ST_RUN);

`ifdef BREAKPOINT_EN
  assign bp_hit = (state_q == ST_BRK);
`else
  assign bp_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cpu_ce && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int DIV = 10;
  localparam int DEB = 4;
`ifdef BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        run_sw     = 1'b0;
  logic        fast_sw    = 1'b0;
  logic        step_btn_n = 1'b1;
  logic [31:0] pc_in      = 32'h0;
  logic [31:0] bp_addr    = 32'h10;

  logic        cpu_ce, halted, bp_hit, heartbeat;
  logic [31:0] cycle_cnt;
  logic        sat_ce, sat_halted, sat_bp, sat_hb;
  logic [3:0]  sat_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ce_seen  = 0;
  int hb_toggles = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.CLK_HZ(100), .SLOW_HZ(10), .DEBOUNCE_CYC(DEB), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .fast_sw(fast_sw), .step_btn_n(step_btn_n),
    .pc_in(pc_in), .bp_addr(bp_addr), .cpu_ce(cpu_ce), .halted(halted),
    .bp_hit(bp_hit), .heartbeat(heartbeat), .cycle_cnt(cycle_cnt)
  );

  cpu_run_ctrl #(.CLK_HZ(100), .SLOW_HZ(10), .DEBOUNCE_CYC(DEB), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .run_sw(run_sw), .fast_sw(fast_sw), .step_btn_n(step_btn_n),
    .pc_in(pc_in), .bp_addr(bp_addr), .cpu_ce(sat_ce), .halted(sat_halted),
    .bp_hit(sat_bp), .heartbeat(sat_hb), .cycle_cnt(sat_cnt)
  );

  // Reference model: inputs delayed two clks, tick from a phase count since
  // reset, debounce as a window of the last DEB synced key samples.
  typedef enum {M_HALT, M_RUN, M_BRK} mstate_t;
  mstate_t m_state = M_HALT;
  bit      run_d[2], fast_d[2], step_d[2];
  bit      win[$];
  bit      m_level, m_req, m_ce, m_hb;
  int      m_phase;
  longint  m_cnt;
  int      exp_q[$];
  bit      rs, fs, ss, tk, old_req, flip, want, ce_n;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_state = M_HALT; m_ce = 0; m_cnt = 0; m_hb = 0; m_phase = 0;
      run_d = '{0, 0}; fast_d = '{0, 0}; step_d = '{1, 1};
      win.delete(); m_level = 1; m_req = 0;
    end else begin
      rs = run_d[0]; fs = fast_d[0]; ss = step_d[0];
      run_d[0] = run_d[1];   run_d[1] = run_sw;
      fast_d[0] = fast_d[1]; fast_d[1] = fast_sw;
      step_d[0] = step_d[1]; step_d[1] = step_btn_n;
      tk = (m_phase == DIV - 1);
      m_phase = (m_phase + 1) % DIV;
      if (tk) m_hb = ~m_hb;
      if (m_ce && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      win.push_back(ss);
      if (win.size() > DEB) void'(win.pop_front());
      flip = 0;
      if (win.size() == DEB) begin
        flip = 1;
        foreach (win[k]) if (win[k] == m_level) flip = 0;
      end
      if (flip) m_level = ss;
      old_req = m_req;
      m_req = flip && !ss;
      ce_n = 0;
      case (m_state)
        M_HALT: begin
          ce_n = old_req;
          if (rs) m_state = M_RUN;
        end
        M_RUN: begin
          if (!rs) m_state = M_HALT;
          else begin
            want = fs || tk;
            if (BP_EN && want && pc_in == bp_addr) m_state = M_BRK;
            else ce_n = want;
          end
        end
        default: begin
          ce_n = old_req;
          if (!rs) m_state = M_HALT;
        end
      endcase
      m_ce = ce_n;
      if (ce_n) exp_q.push_back(cyc);
    end
  end

  // Monitor: pops an expected pulse whenever the DUT issues cpu_ce, and
  // checks the status outputs of both instances every clk.
  int         e_cyc;
  bit         prev_hb = 0;
  logic [42:0] st_act, st_exp;
  longint     m_sat;

  initial forever begin
    @(negedge clk);
    if (cpu_ce === 1'b1) begin
      ce_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ce_unexpected actual_cycle=%0d expected=none", cyc);
      end else begin
        e_cyc = exp_q.pop_front();
        if (e_cyc != cyc) begin
          failures++;
          $display("FAIL ce_timing actual_cycle=%0d expected_cycle=%0d", cyc, e_cyc);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0] <= cyc) begin
      checks++;
      failures++;
      $display("FAIL ce_missed actual=none expected_cycle=%0d", exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (heartbeat !== prev_hb) hb_toggles++;
    prev_hb = heartbeat;
    m_sat  = (m_cnt > 15) ? 15 : m_cnt;
    st_act = {halted, bp_hit, heartbeat, sat_ce, sat_halted, sat_bp, sat_hb, sat_cnt, cycle_cnt};
    st_exp = {m_state != M_RUN, m_state == M_BRK, m_hb, m_ce, m_state != M_RUN,
              m_state == M_BRK, m_hb, m_sat[3:0], m_cnt[31:0]};
    checks++;
    if (st_act !== st_exp) begin
      failures++;
      $display("FAIL status cycle=%0d actual=%h expected=%h", cyc, st_act, st_exp);
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  int base, hb_base;

  initial begin
    // reset
    nclk(3);
    chk("rst_ce", cpu_ce, 0);
    chk("rst_halted", halted, 1);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_hb", heartbeat, 0);
    base = ce_seen; hb_base = hb_toggles;

    // slow run
    rst = 0; run_sw = 1; fast_sw = 0;
    nclk(100);
    chk("slow_pulses", ce_seen - base, 10);
    chk("slow_hb_toggles", hb_toggles - hb_base, 10);
    chk("slow_halted", halted, 0);
    nclk(1);
    chk("slow_cnt", cycle_cnt, 10);

    // fast run, then stop
    fast_sw = 1;
    nclk(2);
    base = ce_seen;
    nclk(50);
    chk("fast_pulses", ce_seen - base, 50);
    chk("fast_ce_high", cpu_ce, 1);
    chk("sat_cnt_fast", sat_cnt, 15);
    run_sw = 0;
    nclk(3);
    chk("stop_ce", cpu_ce, 0);
    chk("stop_halted", halted, 1);

    // step: glitch, press, hold, release
    base = ce_seen;
    step_btn_n = 0;
    nclk(2);
    step_btn_n = 1;
    nclk(10);
    chk("glitch_no_ce", ce_seen - base, 0);
    step_btn_n = 0;
    nclk(10);
    chk("step_one_ce", ce_seen - base, 1);
    nclk(50);
    chk("step_hold", ce_seen - base, 1);
    step_btn_n = 1;
    nclk(10);
    chk("step_release", ce_seen - base, 1);

    // breakpoint
    pc_in = 32'h10; bp_addr = 32'h10;
    base = ce_seen;
    run_sw = 1;
    if (BP_EN) begin
      nclk(6);
      chk("bp_suppress", ce_seen - base, 0);
      chk("bp_hit", bp_hit, 1);
      chk("bp_halted", halted, 1);
      step_btn_n = 0;
      nclk(10);
      step_btn_n = 1;
      nclk(10);
      chk("bp_step", ce_seen - base, 1);
      chk("bp_stays", bp_hit, 1);
      run_sw = 0;
      nclk(4);
      chk("bp_to_halt", bp_hit, 0);
      pc_in = 32'h20;
      run_sw = 1;
      nclk(6);
      chk("bp_resume", halted, 0);
      chk("bp_resume_ce", cpu_ce, 1);
    end else begin
      nclk(10);
      chk("nobp_pulses", ce_seen - base, 7);
      chk("nobp_hit", bp_hit, 0);
      chk("nobp_halted", halted, 0);
    end

    // randomized segments
    for (int i = 0; i < 40; i++) begin
      run_sw     = ($urandom_range(0, 3) != 0);
      fast_sw    = $urandom_range(0, 1);
      step_btn_n = $urandom_range(0, 1);
      pc_in      = ($urandom_range(0, 2) == 0) ? 32'h10 : $urandom;
      nclk($urandom_range(1, 12));
    end

    // mid-run reset, then saturation
    pc_in = 32'h20; step_btn_n = 1; run_sw = 1; fast_sw = 1;
    nclk(6);
    rst = 1;
    nclk(1);
    chk("midrst_ce", cpu_ce, 0);
    chk("midrst_halted", halted, 1);
    chk("midrst_cnt", cycle_cnt, 0);
    chk("midrst_hb", heartbeat, 0);
    nclk(2);
    rst = 0;
    nclk(25);
    chk("sat_hold", sat_cnt, 15);
    chk("sat_main_cnt", cycle_cnt, 21);
    nclk(5);
    chk("sat_still", sat_cnt, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
